// File: rtl/offset_cnt_pkg.sv
// offset_cnt_pkg: shared encodings for the offset counter.
//   MODE_WRAP / MODE_SAT : boundary behaviour selector
//   dir_e                : per-cycle count direction (hold / up / down)
package offset_cnt_pkg;

  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

endpackage

// File: rtl/offset_cnt_next.sv
// offset_cnt_next: combinational next-count and wrap computation.
//   count     in  current offset
//   step      in  step size, zero-extended to WIDTH
//   limit_q   in  active modulus
//   dir       in  hold / up / down
//   mode      in  MODE_WRAP or MODE_SAT
//   count_nxt out next offset
//   wrap_nxt  out boundary crossed by this update
module offset_cnt_next
  import offset_cnt_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 8
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit_q,
  input  dir_e              dir,
  input  logic              mode,
  output logic [WIDTH-1:0]  count_nxt,
  output logic              wrap_nxt
);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] lim_x;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] over;
  logic [WIDTH:0] deficit;

  // Saturated upper bound: last legal offset, or 0 for an empty buffer.
  function automatic logic [WIDTH-1:0] sat_hi(input logic [WIDTH:0] lim);
    if (lim == '0) return '0;
    else           return WIDTH'(lim - 1'b1);
  endfunction

  // Up-wrap folding: an overshoot beyond one full modulus collapses to 0.
  function automatic logic [WIDTH-1:0] fold_up(input logic [WIDTH:0] d,
                                               input logic [WIDTH:0] lim);
    if (d < lim) return WIDTH'(d);
    else         return '0;
  endfunction

  // Down-wrap folding: borrow from the top of the modulus if it fits.
  function automatic logic [WIDTH-1:0] fold_down(input logic [WIDTH:0] def,
                                                 input logic [WIDTH:0] lim);
    if (def <= lim) return WIDTH'(lim - def);
    else            return '0;
  endfunction

  assign cnt_x   = {1'b0, count};
  assign step_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign lim_x   = {1'b0, limit_q};
  assign sum     = cnt_x + step_x;
  assign over    = sum - lim_x;
  assign deficit = step_x - cnt_x;

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    unique case (dir)
      DIR_UP: begin
        if (lim_x == '0) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end else if (step_x == '0) begin
          count_nxt = count;
        end else if (sum >= lim_x) begin
          wrap_nxt  = 1'b1;
          count_nxt = (mode == MODE_WRAP) ? fold_up(over, lim_x) : sat_hi(lim_x);
        end else begin
          count_nxt = WIDTH'(sum);
        end
      end
      DIR_DOWN: begin
        if (step_x == '0) begin
          count_nxt = count;
        end else if (step_x <= cnt_x) begin
          count_nxt = WIDTH'(cnt_x - step_x);
        end else begin
          wrap_nxt  = 1'b1;
          count_nxt = (mode == MODE_WRAP) ? fold_down(deficit, lim_x) : '0;
        end
      end
      default: begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/offset_counter_mod.sv
// offset_counter_mod: modulo offset counter with programmable step,
// up/down count, loadable (optionally deferred) limit and wrap pulse.
//   clk, reset     clock; asynchronous active-high reset
//   clear          synchronous count clear (also a deferred-limit apply point)
//   inc, dec       advance / retreat by step (both together = hold)
//   step           step size
//   load_limit     capture limit_in
//   limit_in       new modulus
//   count          registered offset
//   limit_q        registered active modulus
//   limit_pending  deferred limit waiting (DEFER_LOAD=1 only)
//   wrap           registered one-cycle boundary pulse
module offset_counter_mod
  import offset_cnt_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STEP_W     = 8,
  parameter int WRAP_MODE  = 1,
  parameter int DEFER_LOAD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  input  logic              dec,
  input  logic [STEP_W-1:0] step,
  input  logic              load_limit,
  input  logic [WIDTH-1:0]  limit_in,
  output logic [WIDTH-1:0]  count,
  output logic [WIDTH-1:0]  limit_q,
  output logic              limit_pending,
  output logic              wrap
);

  localparam logic MODE = (WRAP_MODE != 0) ? MODE_WRAP : MODE_SAT;

  dir_e             dir;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             apply;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] limit_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pending_q, pending_d;

  always_comb begin
    dir = DIR_HOLD;
    if (!clear && (inc ^ dec)) dir = inc ? DIR_UP : DIR_DOWN;
  end

  offset_cnt_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .count     (count_q),
    .step      (step),
    .limit_q   (limit_q),
    .dir       (dir),
    .mode      (MODE),
    .count_nxt (count_nxt),
    .wrap_nxt  (wrap_nxt)
  );

  always_comb begin
    count_d   = clear ? '0 : count_nxt;
    wrap_d    = clear ? 1'b0 : wrap_nxt;
    apply     = (DEFER_LOAD != 0) &&
                (clear || wrap_d || (!inc && !dec && (count_q == '0)));
    limit_d   = limit_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (DEFER_LOAD == 0) begin
      pending_d = 1'b0;
      if (load_limit) limit_d = limit_in;
    end else if (load_limit && apply) begin
      limit_d   = limit_in;
      pending_d = 1'b0;
    end else if (load_limit) begin
      pend_d    = limit_in;
      pending_d = 1'b1;
    end else if (apply && pending_q) begin
      limit_d   = pend_q;
      pending_d = 1'b0;
    end
  end

  // Register stage: every output is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      wrap_q    <= 1'b0;
      limit_q   <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      limit_q   <= limit_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
    end
  end

  assign count         = count_q;
  assign wrap          = wrap_q;
  assign limit_pending = pending_q;

endmodule

// File: tb/tb_offset_counter_mod.sv
// Four DUT variants (WRAP_MODE x DEFER_LOAD) share one stimulus stream.
// Index k: bit0 = WRAP_MODE, bit1 = DEFER_LOAD.
module tb_offset_counter_mod;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0, inc = 1'b0, dec = 1'b0, ld = 1'b0;
  logic [3:0] step = '0;
  logic [7:0] lin = '0;

  logic [7:0] cnt [4];
  logic [7:0] lim [4];
  logic       pnd [4];
  logic       wrp [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      offset_counter_mod #(
        .WIDTH      (8),
        .STEP_W     (4),
        .WRAP_MODE  (g % 2),
        .DEFER_LOAD (g / 2)
      ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .inc           (inc),
        .dec           (dec),
        .step          (step),
        .load_limit    (ld),
        .limit_in      (lin),
        .count         (cnt[g]),
        .limit_q       (lim[g]),
        .limit_pending (pnd[g]),
        .wrap          (wrp[g])
      );
    end
  endgenerate

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] l;
    logic       p;
    logic       w;
  } one_t;
  typedef one_t [3:0] all_t;

  all_t sbq[$];

  // Reference state, plain integers.
  int m_cnt [4];
  int m_lim [4];
  int m_pend[4];
  int m_pp  [4];
  int m_wrap[4];

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0; m_lim[k] = 0; m_pend[k] = 0; m_pp[k] = 0; m_wrap[k] = 0;
    end
  endfunction

  function automatic void model_step(int k, bit c, bit i, bit d, int s, bit l, int li);
    bit wm = k[0];
    bit dl = k[1];
    int cur = m_cnt[k];
    int L = m_lim[k];
    int nc = cur;
    int w = 0;
    bit app;
    if (c) begin
      nc = 0;
    end else if (i && !d) begin
      if (L == 0) begin
        nc = 0; w = 1;
      end else if (s == 0) begin
        nc = cur;
      end else if (cur + s >= L) begin
        w = 1;
        if (wm) nc = (cur + s - L < L) ? cur + s - L : 0;
        else    nc = L - 1;
      end else begin
        nc = cur + s;
      end
    end else if (d && !i) begin
      if (s == 0) begin
        nc = cur;
      end else if (s <= cur) begin
        nc = cur - s;
      end else begin
        w = 1;
        if (wm && L > 0 && (s - cur) <= L) nc = L - (s - cur);
        else                               nc = 0;
      end
    end
    app = dl && (c || (w != 0) || (!i && !d && cur == 0));
    if (!dl) begin
      if (l) m_lim[k] = li;
    end else if (l && app) begin
      m_lim[k] = li; m_pp[k] = 0;
    end else if (l) begin
      m_pend[k] = li; m_pp[k] = 1;
    end else if (app && m_pp[k] != 0) begin
      m_lim[k] = m_pend[k]; m_pp[k] = 0;
    end
    m_cnt[k] = nc;
    m_wrap[k] = w;
  endfunction

  task automatic cyc(bit c, bit i, bit d, int s, bit l, int li);
    all_t e;
    @(negedge clk);
    clear = c; inc = i; dec = d; step = s[3:0]; ld = l; lin = li[7:0];
    for (int k = 0; k < 4; k++) begin
      model_step(k, c, i, d, s, l, li);
      e[k].c = m_cnt[k][7:0];
      e[k].l = m_lim[k][7:0];
      e[k].p = m_pp[k][0];
      e[k].w = m_wrap[k][0];
    end
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_cnt[%0d]", k), int'(cnt[k]), 0);
      chk($sformatf("rst_lim[%0d]", k), int'(lim[k]), 0);
      chk($sformatf("rst_pnd[%0d]", k), int'(pnd[k]), 0);
      chk($sformatf("rst_wrp[%0d]", k), int'(wrp[k]), 0);
    end
    model_reset();
    clear = 1'b0; inc = 1'b0; dec = 1'b0; ld = 1'b0; step = '0; lin = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: one expected entry per clocked update.
  initial begin
    all_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("sb_cnt[%0d]", k), int'(cnt[k]), int'(e[k].c));
          chk($sformatf("sb_lim[%0d]", k), int'(lim[k]), int'(e[k].l));
          chk($sformatf("sb_pnd[%0d]", k), int'(pnd[k]), int'(e[k].p));
          chk($sformatf("sb_wrp[%0d]", k), int'(wrp[k]), int'(e[k].w));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1 [7] = '{1, 2, 3, 4, 0, 1, 2};
    int t2 [4] = '{3, 6, 9, 2};
    int t4 [3] = '{1, 2, 0};
    model_reset();

    // T1: limit 5, step 1
    rst_pulse();
    cyc(0, 0, 0, 0, 1, 5);
    for (int n = 0; n < 7; n++) begin
      cyc(0, 1, 0, 1, 0, 0);
      chk($sformatf("t1_cnt%0d", n), int'(cnt[1]), t1[n]);
      chk($sformatf("t1_wrp%0d", n), int'(wrp[1]), (n == 4) ? 1 : 0);
    end

    // T2: limit 10, step 3 up then down
    rst_pulse();
    cyc(0, 0, 0, 0, 1, 10);
    for (int n = 0; n < 4; n++) begin
      cyc(0, 1, 0, 3, 0, 0);
      chk($sformatf("t2_cnt%0d", n), int'(cnt[1]), t2[n]);
    end
    chk("t2_wrp_up", int'(wrp[1]), 1);
    cyc(0, 0, 1, 3, 0, 0);
    chk("t2_cnt_dn", int'(cnt[1]), 9);
    chk("t2_wrp_dn", int'(wrp[1]), 1);

    // T3: saturate mode, limit 8
    rst_pulse();
    cyc(0, 0, 0, 0, 1, 8);
    cyc(0, 1, 0, 5, 0, 0);
    chk("t3_cnt0", int'(cnt[0]), 5);
    cyc(0, 1, 0, 5, 0, 0);
    chk("t3_cnt1", int'(cnt[0]), 7);
    chk("t3_wrp1", int'(wrp[0]), 1);
    cyc(0, 0, 1, 6, 0, 0);
    chk("t3_cnt2", int'(cnt[0]), 1);
    cyc(0, 0, 1, 6, 0, 0);
    chk("t3_cnt3", int'(cnt[0]), 0);
    chk("t3_wrp3", int'(wrp[0]), 1);

    // T4: deferred load
    rst_pulse();
    cyc(0, 0, 0, 0, 1, 6);
    for (int n = 0; n < 4; n++) cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 3);
    chk("t4_pnd_set", int'(pnd[3]), 1);
    chk("t4_lim_old", int'(lim[3]), 6);
    cyc(0, 1, 0, 1, 0, 0);
    chk("t4_cnt5", int'(cnt[3]), 5);
    cyc(0, 1, 0, 1, 0, 0);
    chk("t4_cnt_wrap", int'(cnt[3]), 0);
    chk("t4_wrp", int'(wrp[3]), 1);
    chk("t4_lim_new", int'(lim[3]), 3);
    chk("t4_pnd_clr", int'(pnd[3]), 0);
    for (int n = 0; n < 3; n++) begin
      cyc(0, 1, 0, 1, 0, 0);
      chk($sformatf("t4_cnt_after%0d", n), int'(cnt[3]), t4[n]);
    end

    // T5: zero limit after reset
    rst_pulse();
    for (int n = 0; n < 3; n++) begin
      cyc(0, 1, 0, 1, 0, 0);
      chk($sformatf("t5_cnt%0d", n), int'(cnt[1]), 0);
      chk($sformatf("t5_wrp%0d", n), int'(wrp[0]), 1);
    end
    cyc(0, 1, 1, 1, 0, 0);
    chk("t5_both_wrp", int'(wrp[1]), 0);

    // T6: async reset with pending limit, then clear beats inc
    rst_pulse();
    cyc(0, 0, 0, 0, 1, 20);
    cyc(0, 1, 0, 7, 0, 0);
    cyc(0, 0, 0, 0, 1, 9);
    chk("t6_cnt7", int'(cnt[3]), 7);
    chk("t6_pnd", int'(pnd[3]), 1);
    rst_pulse();
    cyc(0, 0, 0, 0, 1, 20);
    cyc(0, 1, 0, 5, 0, 0);
    cyc(1, 1, 0, 3, 0, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("t6_clr[%0d]", k), int'(cnt[k]), 0);

    // Randomised traffic
    rst_pulse();
    for (int n = 0; n < 3000; n++) begin
      bit c  = ($urandom_range(0, 15) == 0);
      bit i  = 1'($urandom_range(0, 1));
      bit d  = 1'($urandom_range(0, 1));
      bit l  = ($urandom_range(0, 7) == 0);
      int s  = int'($urandom_range(0, 15));
      int li = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                           : int'($urandom_range(0, 24));
      if ($urandom_range(0, 299) == 0) rst_pulse();
      cyc(c, i, d, s, l, li);
    end

    @(posedge clk);
    #3;
    chk("sb_drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
